// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Two-port round-robin arbiter with burst lock in front of the
//            sectioned data memory; 3-stage access/response pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
   parameter int         DATA_W    = 32,
   parameter int         ADDR_W    = 32,
   parameter int         SEL_LO    = 16,
   parameter logic [3:0] SECT_MASK = 4'b0111
) (
   input  logic              CLK,
   input  logic              RST,

   input  logic              m0_req_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   input  logic              m0_wren_i,
   input  logic              m0_lock_i,
   output logic              m0_ack_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_data_o,
   output logic              m0_err_o,

   input  logic              m1_req_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   input  logic              m1_wren_i,
   input  logic              m1_lock_i,
   output logic              m1_ack_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_data_o,
   output logic              m1_err_o,

   output logic [ADDR_W-1:0] mem_address_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              mem_wren_o,
   input  logic [DATA_W-1:0] mem_q_i
);

   localparam logic c_PORT0 = 1'b0;
   localparam logic c_PORT1 = 1'b1;

   // arbitration state
   logic r_lock;
   logic r_owner;
   logic r_last;

   // grant and selected request
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_accept;
   logic              w_owner_req;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_wren;
   logic              w_lock;
   logic [1:0]        w_sel;
   logic              w_populated;

   // stage 1 (memory access cycle)
   logic              r_s1_valid;
   logic              r_s1_port;
   logic              r_s1_wren;
   logic              r_s1_err;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_data;
   logic              r_mem_wren;

   // stage 2 (memory data valid)
   logic              r_s2_valid;
   logic              r_s2_port;
   logic              r_s2_wren;
   logic              r_s2_err;
   logic [DATA_W-1:0] w_rdata;

   // stage 3 (response)
   logic              r_m0_rvalid;
   logic              r_m0_err;
   logic [DATA_W-1:0] r_m0_data;
   logic              r_m1_rvalid;
   logic              r_m1_err;
   logic [DATA_W-1:0] r_m1_data;

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   assign w_owner_req = (r_owner == c_PORT1) ? m1_req_i : m0_req_i;

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (r_lock && w_owner_req) begin
         w_gnt0 = (r_owner == c_PORT0);
         w_gnt1 = (r_owner == c_PORT1);
      end else if (m0_req_i && m1_req_i) begin
         // tie goes to the port that did not win last
         w_gnt0 = (r_last == c_PORT1);
         w_gnt1 = (r_last == c_PORT0);
      end else begin
         w_gnt0 = m0_req_i;
         w_gnt1 = m1_req_i;
      end
   end

   assign w_accept = w_gnt0 | w_gnt1;
   assign m0_ack_o = w_gnt0;
   assign m1_ack_o = w_gnt1;

   assign w_addr  = w_gnt1 ? m1_addr_i : m0_addr_i;
   assign w_wdata = w_gnt1 ? m1_data_i : m0_data_i;
   assign w_wren  = w_gnt1 ? m1_wren_i : m0_wren_i;
   assign w_lock  = w_gnt1 ? m1_lock_i : m0_lock_i;

   assign w_sel       = w_addr[SEL_LO+1:SEL_LO];
   assign w_populated = SECT_MASK[w_sel];

   // A cycle without an accept implies the owner is not requesting, so the
   // lock is released there; any accept re-arms it from the winner's lock_i.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_lock  <= 1'b0;
         r_owner <= c_PORT0;
         r_last  <= c_PORT1;
      end else if (w_accept) begin
         r_lock  <= w_lock;
         r_owner <= w_gnt1;
         r_last  <= w_gnt1;
      end else begin
         r_lock  <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Stage 1: registered access to the memory manager
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_s1_valid <= 1'b0;
         r_s1_port  <= c_PORT0;
         r_s1_wren  <= 1'b0;
         r_s1_err   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_mem_wren <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         r_mem_wren <= w_accept & w_wren & w_populated;
         if (w_accept) begin
            r_s1_port  <= w_gnt1;
            r_s1_wren  <= w_wren;
            r_s1_err   <= ~w_populated;
            r_mem_addr <= w_addr;
            r_mem_data <= w_wdata;
         end
      end
   end

   assign mem_address_o = r_mem_addr;
   assign mem_data_o    = r_mem_data;
   assign mem_wren_o    = r_mem_wren;

   // ------------------------------------------------------------------------
   // Stage 2: memory read data arrives this cycle
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_s2_valid <= 1'b0;
         r_s2_port  <= c_PORT0;
         r_s2_wren  <= 1'b0;
         r_s2_err   <= 1'b0;
      end else begin
         r_s2_valid <= r_s1_valid;
         r_s2_port  <= r_s1_port;
         r_s2_wren  <= r_s1_wren;
         r_s2_err   <= r_s1_err;
      end
   end

   assign w_rdata = r_s2_err ? '0 : mem_q_i;

   // ------------------------------------------------------------------------
   // Stage 3: response routed by the carried port id
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_m0_rvalid <= 1'b0;
         r_m0_err    <= 1'b0;
         r_m0_data   <= '0;
         r_m1_rvalid <= 1'b0;
         r_m1_err    <= 1'b0;
         r_m1_data   <= '0;
      end else begin
         r_m0_rvalid <= r_s2_valid & (r_s2_port == c_PORT0);
         r_m1_rvalid <= r_s2_valid & (r_s2_port == c_PORT1);
         r_m0_err    <= r_s2_valid & (r_s2_port == c_PORT0) & r_s2_err;
         r_m1_err    <= r_s2_valid & (r_s2_port == c_PORT1) & r_s2_err;
         // write responses leave the read data register untouched
         if (r_s2_valid && !r_s2_wren) begin
            if (r_s2_port == c_PORT1) begin
               r_m1_data <= w_rdata;
            end else begin
               r_m0_data <= w_rdata;
            end
         end
      end
   end

   assign m0_rvalid_o = r_m0_rvalid;
   assign m0_err_o    = r_m0_err;
   assign m0_data_o   = r_m0_data;
   assign m1_rvalid_o = r_m1_rvalid;
   assign m1_err_o    = r_m1_err;
   assign m1_data_o   = r_m1_data;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Self-checking bench for data_mem_arbiter with a sectioned memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

   logic        CLK;
   logic        RST;
   logic        m0_req_i, m0_wren_i, m0_lock_i;
   logic [31:0] m0_addr_i, m0_data_i;
   logic        m0_ack_o, m0_rvalid_o, m0_err_o;
   logic [31:0] m0_data_o;
   logic        m1_req_i, m1_wren_i, m1_lock_i;
   logic [31:0] m1_addr_i, m1_data_i;
   logic        m1_ack_o, m1_rvalid_o, m1_err_o;
   logic [31:0] m1_data_o;
   logic [31:0] mem_address_o, mem_data_o, mem_q_i;
   logic        mem_wren_o;

   data_mem_arbiter dut (
      .CLK(CLK), .RST(RST),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
      .m0_wren_i(m0_wren_i), .m0_lock_i(m0_lock_i), .m0_ack_o(m0_ack_o),
      .m0_rvalid_o(m0_rvalid_o), .m0_data_o(m0_data_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
      .m1_wren_i(m1_wren_i), .m1_lock_i(m1_lock_i), .m1_ack_o(m1_ack_o),
      .m1_rvalid_o(m1_rvalid_o), .m1_data_o(m1_data_o), .m1_err_o(m1_err_o),
      .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
      .mem_wren_o(mem_wren_o), .mem_q_i(mem_q_i)
   );

   always #5 CLK = ~CLK;

   // sectioned memory: index = {section, word[5:0]}, 1-cycle synchronous read
   logic [31:0] mem [0:255];
   logic        pre_en;
   logic [7:0]  pre_idx;
   logic [31:0] pre_dat;

   function automatic logic [7:0] midx(input logic [31:0] a);
      return {a[17:16], a[7:2]};
   endfunction

   always @(posedge CLK) begin
      mem_q_i <= mem[midx(mem_address_o)];
      if (pre_en) mem[pre_idx] <= pre_dat;
      else if (mem_wren_o) mem[midx(mem_address_o)] <= mem_data_o;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_port(input int p, input bit req, input logic [31:0] a,
                           input logic [31:0] d, input bit w, input bit l);
      if (p == 0) begin
         m0_req_i = req; m0_addr_i = a; m0_data_i = d; m0_wren_i = w; m0_lock_i = l;
      end else begin
         m1_req_i = req; m1_addr_i = a; m1_data_i = d; m1_wren_i = w; m1_lock_i = l;
      end
   endtask

   function automatic logic ackp(input int p);
      return (p == 0) ? m0_ack_o : m1_ack_o;
   endfunction
   function automatic logic rvp(input int p);
      return (p == 0) ? m0_rvalid_o : m1_rvalid_o;
   endfunction
   function automatic logic errp(input int p);
      return (p == 0) ? m0_err_o : m1_err_o;
   endfunction
   function automatic logic [31:0] datp(input int p);
      return (p == 0) ? m0_data_o : m1_data_o;
   endfunction

   task automatic preload(input logic [7:0] idx, input logic [31:0] d);
      pre_en = 1'b1; pre_idx = idx; pre_dat = d;
      tick();
      pre_en = 1'b0;
   endtask

   // one isolated access from port p; checks C0 ack, C1 memory side, C3 response
   task automatic single(input int p, input logic [31:0] a, input logic [31:0] d,
                         input bit w, input logic [31:0] ed, input bit ee, input string nm);
      set_port(p, 1'b1, a, d, w, 1'b0);
      @(negedge CLK); chk({nm, "_ack"}, ackp(p), 1);
      tick();
      set_port(p, 1'b0, a, d, w, 1'b0);
      @(negedge CLK);
      chk({nm, "_addr"}, mem_address_o, a);
      chk({nm, "_wren"}, mem_wren_o, w && !ee);
      tick();
      @(negedge CLK); chk({nm, "_rv_early"}, rvp(p), 0);
      tick();
      @(negedge CLK);
      chk({nm, "_rv"}, rvp(p), 1);
      chk({nm, "_data"}, datp(p), ed);
      chk({nm, "_err"}, errp(p), ee);
      tick();
   endtask

   typedef struct {
      bit req0, req1, lk0, lk1;
      bit a0, a1, v0, v1;
   } vec_t;
   vec_t tbl [15];

   typedef struct {
      int          due;
      int          port;
      bit          rd;
      bit          err;
      logic [31:0] data;
   } resp_t;
   resp_t q [$];
   resp_t r;

   logic [31:0] ref_mem [0:255];
   logic [3:0]  mask;
   bit          act [2];
   bit          rw [2];
   bit          rl [2];
   logic [31:0] ra [2];
   logic [31:0] rd [2];
   logic [31:0] exp_hold [2];
   bit          exp_rv [2];
   bit          exp_er [2];
   bit          req [2];
   int          g, ref_last, ref_owner;
   bit          ref_lock, wren_exp, pop;
   logic [31:0] addr_exp;
   logic [7:0]  ix;

   initial begin
      CLK = 1'b0; RST = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_dat = '0;
      mask = 4'b0111;
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);

      tbl[0]  = '{1,1,0,0, 1,0, 0,0};
      tbl[1]  = '{1,1,0,0, 0,1, 0,0};
      tbl[2]  = '{1,1,0,0, 1,0, 0,0};
      tbl[3]  = '{1,1,0,0, 0,1, 1,0};
      tbl[4]  = '{0,1,0,1, 0,1, 0,1};
      tbl[5]  = '{1,1,0,0, 0,1, 1,0};
      tbl[6]  = '{1,1,0,0, 1,0, 0,1};
      tbl[7]  = '{0,0,0,0, 0,0, 0,1};
      tbl[8]  = '{1,0,1,0, 1,0, 0,1};
      tbl[9]  = '{0,1,0,0, 0,1, 1,0};
      tbl[10] = '{1,1,0,0, 1,0, 0,0};
      tbl[11] = '{0,0,0,0, 0,0, 1,0};
      tbl[12] = '{0,0,0,0, 0,0, 0,1};
      tbl[13] = '{0,0,0,0, 0,0, 1,0};
      tbl[14] = '{0,0,0,0, 0,0, 0,0};

      // reset state
      tick();
      preload(midx(32'h0001_0004), 32'hDEAD_BEEF);
      @(negedge CLK);
      chk("rst_ack0", m0_ack_o, 0);     chk("rst_ack1", m1_ack_o, 0);
      chk("rst_rv0", m0_rvalid_o, 0);   chk("rst_rv1", m1_rvalid_o, 0);
      chk("rst_err0", m0_err_o, 0);     chk("rst_err1", m1_err_o, 0);
      chk("rst_d0", m0_data_o, 0);      chk("rst_d1", m1_data_o, 0);
      chk("rst_maddr", mem_address_o, 0);
      chk("rst_mdata", mem_data_o, 0);
      chk("rst_mwren", mem_wren_o, 0);
      tick();
      RST = 1'b0;

      // arbitration table: round-robin ties, lock hold, lock release on idle owner
      for (int i = 0; i < 15; i++) begin
         set_port(0, tbl[i].req0, 32'h0000_0000, 0, 0, tbl[i].lk0);
         set_port(1, tbl[i].req1, 32'h0000_0004, 0, 0, tbl[i].lk1);
         @(negedge CLK);
         chk($sformatf("tbl%0d_ack0", i), m0_ack_o, tbl[i].a0);
         chk($sformatf("tbl%0d_ack1", i), m1_ack_o, tbl[i].a1);
         chk($sformatf("tbl%0d_rv0", i), m0_rvalid_o, tbl[i].v0);
         chk($sformatf("tbl%0d_rv1", i), m1_rvalid_o, tbl[i].v1);
         chk($sformatf("tbl%0d_wren", i), mem_wren_o, 0);
         tick();
      end

      single(0, 32'h0001_0004, 0, 0, 32'hDEAD_BEEF, 0, "rd_sec1");

      // lock burst: port 1 keeps the grant for 4 writes while port 0 waits
      set_port(0, 1, 32'h0001_0004, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         set_port(1, 1, 32'h20 + 32'(4 * k), 32'h1000_0000 + 32'(k), 1, k < 3);
         @(negedge CLK);
         chk($sformatf("lb%0d_ack1", k), m1_ack_o, 1);
         chk($sformatf("lb%0d_ack0", k), m0_ack_o, 0);
         tick();
      end
      set_port(1, 0, 0, 0, 0, 0);
      @(negedge CLK);
      chk("lb_m0_ack", m0_ack_o, 1);
      chk("lb_wren", mem_wren_o, 1);
      tick();
      set_port(0, 0, 0, 0, 0, 0);
      repeat (4) tick();
      for (int k = 0; k < 4; k++)
         single(1, 32'h20 + 32'(4 * k), 0, 0, 32'h1000_0000 + 32'(k), 0, $sformatf("lb_rb%0d", k));

      // unpopulated section
      single(0, 32'h0003_0000, 32'h1234, 1, 32'hDEAD_BEEF, 1, "unpop_wr");
      single(0, 32'h0003_0000, 0, 0, 32'h0, 1, "unpop_rd");

      // write then read of the same address, back to back
      set_port(0, 1, 32'h10, 32'hA5A5_A5A5, 1, 0);
      @(negedge CLK); chk("wtr_ack_w", m0_ack_o, 1);
      tick();
      set_port(0, 1, 32'h10, 0, 0, 0);
      @(negedge CLK);
      chk("wtr_ack_r", m0_ack_o, 1);
      chk("wtr_wren", mem_wren_o, 1);
      chk("wtr_addr", mem_address_o, 32'h10);
      chk("wtr_wdata", mem_data_o, 32'hA5A5_A5A5);
      tick();
      set_port(0, 0, 0, 0, 0, 0);
      tick();
      @(negedge CLK);
      chk("wtr_rv_w", m0_rvalid_o, 1);
      chk("wtr_err_w", m0_err_o, 0);
      chk("wtr_hold_w", m0_data_o, 0);
      tick();
      @(negedge CLK);
      chk("wtr_rv_r", m0_rvalid_o, 1);
      chk("wtr_data_r", m0_data_o, 32'hA5A5_A5A5);
      tick();
      @(negedge CLK);
      chk("wtr_rv_idle", m0_rvalid_o, 0);
      chk("wtr_err_idle", m0_err_o, 0);
      tick();

      // reset in C1: write enable must drop without waiting for a clock edge
      set_port(0, 1, 32'h40, 32'h77, 1, 0);
      @(negedge CLK); chk("rmf_ack", m0_ack_o, 1);
      tick();
      set_port(0, 0, 0, 0, 0, 0);
      chk("rmf_wren_c1", mem_wren_o, 1);
      #2 RST = 1'b1;
      #1;
      chk("rmf_wren_async", mem_wren_o, 0);
      chk("rmf_addr_async", mem_address_o, 0);
      tick();
      tick();
      RST = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk($sformatf("rmf_rv0_%0d", k), m0_rvalid_o, 0);
         chk($sformatf("rmf_rv1_%0d", k), m1_rvalid_o, 0);
         tick();
      end
      set_port(0, 1, 0, 0, 0, 0);
      set_port(1, 1, 4, 0, 0, 0);
      @(negedge CLK);
      chk("rmf_tie_ack0", m0_ack_o, 1);
      chk("rmf_tie_ack1", m1_ack_o, 0);
      tick();
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);

      // randomized traffic against a transaction-level reference
      RST = 1'b1;
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < 8; w++) begin
            ix = {2'(s), 6'(w)};
            ref_mem[ix] = $urandom;
            preload(ix, ref_mem[ix]);
         end
      RST = 1'b0;
      ref_last = 1; ref_owner = 0; ref_lock = 1'b0;
      wren_exp = 1'b0; addr_exp = '0;
      exp_hold[0] = '0; exp_hold[1] = '0;
      act[0] = 1'b0; act[1] = 1'b0;

      for (int c = 0; c < 1500; c++) begin
         @(negedge CLK);
         req[0] = act[0]; req[1] = act[1];
         if (ref_lock && req[ref_owner]) g = ref_owner;
         else if (req[0] && req[1])      g = 1 - ref_last;
         else if (req[0])                g = 0;
         else if (req[1])                g = 1;
         else                            g = -1;
         chk("rnd_ack0", m0_ack_o, g == 0);
         chk("rnd_ack1", m1_ack_o, g == 1);

         exp_rv[0] = 0; exp_rv[1] = 0; exp_er[0] = 0; exp_er[1] = 0;
         if (q.size() > 0 && q[0].due == c) begin
            r = q.pop_front();
            exp_rv[r.port] = 1'b1;
            exp_er[r.port] = r.err;
            if (r.rd) exp_hold[r.port] = r.data;
         end
         chk("rnd_rv0", m0_rvalid_o, exp_rv[0]);
         chk("rnd_rv1", m1_rvalid_o, exp_rv[1]);
         chk("rnd_err0", m0_err_o, exp_er[0]);
         chk("rnd_err1", m1_err_o, exp_er[1]);
         chk("rnd_d0", m0_data_o, exp_hold[0]);
         chk("rnd_d1", m1_data_o, exp_hold[1]);
         chk("rnd_wren", mem_wren_o, wren_exp);
         chk("rnd_maddr", mem_address_o, addr_exp);

         tick();
         if (g >= 0) begin
            pop    = mask[ra[g][17:16]];
            r.due  = c + 3;
            r.port = g;
            r.rd   = !rw[g];
            r.err  = !pop;
            r.data = pop ? ref_mem[midx(ra[g])] : 32'h0;
            if (rw[g] && pop) ref_mem[midx(ra[g])] = rd[g];
            q.push_back(r);
            wren_exp  = rw[g] && pop;
            addr_exp  = ra[g];
            ref_last  = g;
            ref_owner = g;
            ref_lock  = rl[g];
            act[g]    = 1'b0;
         end else begin
            wren_exp = 1'b0;
            ref_lock = 1'b0;
         end
         for (int p = 0; p < 2; p++) begin
            if (!act[p] && c < 1490 && $urandom_range(99) < 55) begin
               act[p] = 1'b1;
               ra[p]  = (32'($urandom_range(3)) << 16) | (32'($urandom_range(7)) << 2);
               rd[p]  = $urandom;
               rw[p]  = ($urandom_range(1) == 1);
               rl[p]  = ($urandom_range(99) < 35);
            end
            set_port(p, act[p], ra[p], rd[p], rw[p], rl[p]);
         end
      end
      chk("rnd_drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
